onchip_mem_arbiter: RTL

Two-master arbiter that shares the single-port 1024x32 on-chip RAM between the processor data port (m0) and a secondary master such as DMA or a peripheral bridge (m1). It sits between the two Avalon-MM masters and the RAM slave port. It grants at most one access per clock, enforces fair burst-limited alternation, and returns read data with the RAM's fixed one-cycle latency through a per-master `readdatavalid`.

---
 rtl/onchip_mem_pkg.sv | 13 +
 rtl/onchip_mem_arbiter_rr_grant2.sv | 92 +++++++++
 rtl/onchip_mem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
package onchip_mem_pkg;
  localparam int ADDR_W         = 10;
  localparam int DATA_W         = 32;
  localparam int BE_W           = DATA_W / 8;
  localparam int MEM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/onchip_mem_arbiter_rr_grant2.sv
// Two-requester grant FSM: burst-limited alternation under contention,
// least-recently-granted tie break from IDLE. Grants are combinational.
module rr_grant2
  import onchip_mem_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam logic [3:0] HOLD_LIM = 4'(BURST_MAX - 1);

  arb_state_t state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       last_q, last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= 4'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (reset) begin
      state_d = IDLE;
      hold_d  = 4'd0;
      last_d  = 1'b1;
    end else begin
      // hold counts extra owner grants taken while the other master waits
      case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
          hold_d = 4'd0;
        end
        OWN0: begin
          if (req0 && (!req1 || (hold_q < HOLD_LIM))) begin
            gnt0   = 1'b1;
            hold_d = req1 ? (hold_q + 4'd1) : 4'd0;
          end else begin
            gnt1   = req1;
            hold_d = 4'd0;
          end
        end
        OWN1: begin
          if (req1 && (!req0 || (hold_q < HOLD_LIM))) begin
            gnt1   = 1'b1;
            hold_d = req0 ? (hold_q + 4'd1) : 4'd0;
          end else begin
            gnt0   = req0;
            hold_d = 4'd0;
          end
        end
        default: begin
          hold_d = 4'd0;
        end
      endcase

      if (gnt0) begin
        state_d = OWN0;
        last_d  = 1'b0;
      end else if (gnt1) begin
        state_d = OWN1;
        last_d  = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between two Avalon-MM masters and
// routes the one-cycle-latency read data back to the master that issued it.
module onchip_mem_arbiter #(
  parameter int ADDR_W    = onchip_mem_pkg::ADDR_W,
  parameter int DATA_W    = onchip_mem_pkg::DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W / 8;

  logic req0, req1, gnt0, gnt1;
  logic rd_valid_q, rd_valid_d;
  logic rd_owner_q, rd_owner_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  rr_grant2 #(
    .BURST_MAX (BURST_MAX)
  ) u_grant (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    mem_address    = {ADDR_W{1'b0}};
    mem_byteenable = {BE_W{1'b0}};
    mem_writedata  = {DATA_W{1'b0}};
    mem_write      = 1'b0;
    if (gnt0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end else if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end else begin
      mem_write      = 1'b0;
    end
  end

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_clken      = ~reset;
  assign m0_waitrequest = reset | (req0 & ~gnt0);
  assign m1_waitrequest = reset | (req1 & ~gnt1);

  always_comb begin
    rd_valid_d = (gnt0 & m0_read) | (gnt1 & m1_read);
    if (gnt1) begin
      rd_owner_d = 1'b1;
    end else if (gnt0) begin
      rd_owner_d = 1'b0;
    end else begin
      rd_owner_d = rd_owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // gating with reset drops a read return that lands on a reset cycle
  assign m0_readdatavalid = rd_valid_q & ~rd_owner_q & ~reset;
  assign m1_readdatavalid = rd_valid_q & rd_owner_q & ~reset;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule
